// File: rtl/axi_ip_rx.sv
// IPv4 receive parser: validates the fixed 20-byte header and forwards the UDP payload with Ethernet padding trimmed.
// Optional header checksum verification is built when AXI_IP_RX_CHECKSUM_EN is defined.
module axi_ip_rx #(
    parameter logic [15:0] IP_MSB = 16'hc0a8,
    parameter logic [15:0] IP_LSB = 16'h0602
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    input  logic        m_axis_tready,
    output logic        ip_hdr_valid,
    output logic [31:0] ip_hdr_src_ip,
    output logic [31:0] ip_hdr_dst_ip,
    output logic [15:0] ip_hdr_length,
    output logic        ip_drop
);

    typedef enum logic [1:0] {HDR, PAYLOAD, DROP} state_t;

    state_t      state_reg;
    logic [4:0]  idx_reg;
    logic [15:0] total_len_reg;
    logic [15:0] rem_reg;
    logic [31:0] src_reg;
    logic [23:0] dst_hi_reg;
    logic        ver_ok_reg;
    logic        frag_bad_reg;
    logic        proto_ok_reg;

    logic        accept;
    logic [31:0] dst_full;
    logic        dst_ok;
    logic        csum_ok;
    logic        hdr_ok;

`ifdef AXI_IP_RX_CHECKSUM_EN
    logic [7:0]  csum_hi_reg;
    logic [15:0] csum_reg;
    logic [15:0] csum_next;

    function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    // Word completes on each odd index; index 1 starts a fresh sum.
    assign csum_next = csum_add((idx_reg == 5'd1) ? 16'd0 : csum_reg, {csum_hi_reg, s_axis_tdata});
    assign csum_ok   = (csum_next == 16'hffff);
`else
    assign csum_ok = 1'b1;
`endif

    assign accept   = s_axis_tvalid && s_axis_tready;
    assign dst_full = {dst_hi_reg, s_axis_tdata};
    assign dst_ok   = (dst_full == {IP_MSB, IP_LSB}) || (dst_full == 32'hffff_ffff);
    assign hdr_ok   = ver_ok_reg && (total_len_reg >= 16'd21) && !frag_bad_reg
                      && proto_ok_reg && dst_ok && csum_ok;

    // Payload path is a straight combinational pass-through while in PAYLOAD.
    always_comb begin
        s_axis_tready = 1'b1;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        if (state_reg == PAYLOAD) begin
            s_axis_tready = m_axis_tready;
            m_axis_tvalid = s_axis_tvalid;
            m_axis_tlast  = (rem_reg == 16'd1) || s_axis_tlast;
            m_axis_tuser  = s_axis_tlast && (rem_reg > 16'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_reg     <= HDR;
            idx_reg       <= 5'd0;
            total_len_reg <= 16'd0;
            rem_reg       <= 16'd0;
            src_reg       <= 32'd0;
            dst_hi_reg    <= 24'd0;
            ver_ok_reg    <= 1'b0;
            frag_bad_reg  <= 1'b0;
            proto_ok_reg  <= 1'b0;
            ip_hdr_valid  <= 1'b0;
            ip_hdr_src_ip <= 32'd0;
            ip_hdr_dst_ip <= 32'd0;
            ip_hdr_length <= 16'd0;
            ip_drop       <= 1'b0;
`ifdef AXI_IP_RX_CHECKSUM_EN
            csum_hi_reg   <= 8'd0;
            csum_reg      <= 16'd0;
`endif
        end else begin
            ip_drop <= 1'b0;
            case (state_reg)
                HDR: begin
                    if (accept) begin
                        case (idx_reg)
                            5'd0: begin
                                ver_ok_reg   <= (s_axis_tdata == 8'h45);
                                ip_hdr_valid <= 1'b0;
                            end
                            5'd2:  total_len_reg[15:8] <= s_axis_tdata;
                            5'd3:  total_len_reg[7:0]  <= s_axis_tdata;
                            5'd6:  frag_bad_reg <= s_axis_tdata[5] || (s_axis_tdata[4:0] != 5'd0);
                            5'd7:  frag_bad_reg <= frag_bad_reg || (s_axis_tdata != 8'd0);
                            5'd9:  proto_ok_reg <= (s_axis_tdata == 8'd17);
                            5'd12, 5'd13, 5'd14, 5'd15: src_reg <= {src_reg[23:0], s_axis_tdata};
                            5'd16, 5'd17, 5'd18: dst_hi_reg <= {dst_hi_reg[15:0], s_axis_tdata};
                            default: ;
                        endcase
`ifdef AXI_IP_RX_CHECKSUM_EN
                        if (!idx_reg[0])
                            csum_hi_reg <= s_axis_tdata;
                        else
                            csum_reg <= csum_next;
`endif
                        if (s_axis_tlast) begin
                            ip_drop <= 1'b1;
                            idx_reg <= 5'd0;
                        end else if (idx_reg == 5'd19) begin
                            idx_reg <= 5'd0;
                            if (hdr_ok) begin
                                state_reg     <= PAYLOAD;
                                rem_reg       <= total_len_reg - 16'd20;
                                ip_hdr_valid  <= 1'b1;
                                ip_hdr_src_ip <= src_reg;
                                ip_hdr_dst_ip <= dst_full;
                                ip_hdr_length <= total_len_reg - 16'd20;
                            end else begin
                                state_reg <= DROP;
                                ip_drop   <= 1'b1;
                            end
                        end else begin
                            idx_reg <= idx_reg + 5'd1;
                        end
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        rem_reg <= rem_reg - 16'd1;
                        // Frame end wins; reaching the length first means padding follows.
                        if (s_axis_tlast)
                            state_reg <= HDR;
                        else if (rem_reg == 16'd1)
                            state_reg <= DROP;
                    end
                end
                DROP: begin
                    if (accept && s_axis_tlast)
                        state_reg <= HDR;
                end
                default: state_reg <= HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ip_rx.sv
// Directed, table-driven bench for axi_ip_rx plus hand sequences for reset and backpressure.
module tb_axi_ip_rx;
    localparam logic [31:0] LOCAL_IP = 32'hc0a80602;
    localparam logic [31:0] SRC_IP   = 32'hc0a80601;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        m_axis_tready;
    logic        ip_hdr_valid;
    logic [31:0] ip_hdr_src_ip;
    logic [31:0] ip_hdr_dst_ip;
    logic [15:0] ip_hdr_length;
    logic        ip_drop;

    always #5 clk = ~clk;

    axi_ip_rx dut (
        .clk(clk), .aresetn(aresetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .m_axis_tready(m_axis_tready),
        .ip_hdr_valid(ip_hdr_valid), .ip_hdr_src_ip(ip_hdr_src_ip),
        .ip_hdr_dst_ip(ip_hdr_dst_ip), .ip_hdr_length(ip_hdr_length),
        .ip_drop(ip_drop)
    );

    typedef struct {
        logic [31:0] dst;
        logic [7:0]  proto;
        logic [7:0]  b0;
        logic [7:0]  b6;
        logic [15:0] tl;
        bit          bad_csum;
        int          nsend;
        int          pad;
        int          trunc;
        bit          toggle;
        int          exp_drop;
        int          exp_n;
        bit          exp_tuser;
        bit          exp_valid;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       l;
        logic       u;
    } obs_t;

    vec_t       vecs[13];
    logic [7:0] frame[$];
    obs_t       out_q[$];
    int         drop_cnt = 0;
    int         total = 0;
    int         passed = 0;

    always @(negedge clk) begin
        if (aresetn && m_axis_tvalid && m_axis_tready)
            out_q.push_back('{d: m_axis_tdata, l: m_axis_tlast, u: m_axis_tuser});
        if (ip_drop)
            drop_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [31:0] dst, input logic [7:0] proto, input logic [7:0] b0,
                                input logic [7:0] b6, input logic [15:0] tl, input bit bad_csum,
                                input int nsend, input int pad, input int trunc, input bit toggle,
                                input int exp_drop, input int exp_n, input bit exp_tuser, input bit exp_valid);
        vec_t v;
        v.dst = dst; v.proto = proto; v.b0 = b0; v.b6 = b6; v.tl = tl; v.bad_csum = bad_csum;
        v.nsend = nsend; v.pad = pad; v.trunc = trunc; v.toggle = toggle;
        v.exp_drop = exp_drop; v.exp_n = exp_n; v.exp_tuser = exp_tuser; v.exp_valid = exp_valid;
        return v;
    endfunction

    task automatic build_frame(input vec_t v);
        logic [7:0]  hdr[20];
        logic [31:0] sum;
        logic [15:0] cs;
        hdr[0] = v.b0;  hdr[1] = 8'h00; hdr[2] = v.tl[15:8]; hdr[3] = v.tl[7:0];
        hdr[4] = 8'h12; hdr[5] = 8'h34; hdr[6] = v.b6;       hdr[7] = 8'h00;
        hdr[8] = 8'h40; hdr[9] = v.proto; hdr[10] = 8'h00;   hdr[11] = 8'h00;
        for (int k = 0; k < 4; k++) begin
            hdr[12+k] = SRC_IP[31-8*k -: 8];
            hdr[16+k] = v.dst[31-8*k -: 8];
        end
        sum = 32'd0;
        for (int k = 0; k < 10; k++) sum = sum + {16'd0, hdr[2*k], hdr[2*k+1]};
        sum = {16'd0, sum[15:0]} + {16'd0, sum[31:16]};
        sum = {16'd0, sum[15:0]} + {16'd0, sum[31:16]};
        cs = ~sum[15:0];
        hdr[10] = cs[15:8];
        hdr[11] = cs[7:0] ^ (v.bad_csum ? 8'h01 : 8'h00);
        frame.delete();
        for (int k = 0; k < 20; k++) frame.push_back(hdr[k]);
        for (int k = 0; k < v.nsend; k++) frame.push_back(8'hA0 + 8'(k));
        for (int k = 0; k < v.pad; k++) frame.push_back(8'h00);
        if (v.trunc > 0)
            while (frame.size() > v.trunc) void'(frame.pop_back());
    endtask

    task automatic send_frame(input vec_t v);
        int  tries;
        bit  acc;
        for (int i = 0; i < frame.size(); i++) begin
            s_axis_tdata  = frame[i];
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = (i == frame.size() - 1);
            tries = 0;
            acc   = 1'b0;
            while (!acc) begin
                m_axis_tready = v.toggle ? ~m_axis_tready : 1'b1;
                @(negedge clk);
                if (v.toggle && i >= 20 && i < 20 + v.exp_n)
                    check("tready_mirror", s_axis_tready, m_axis_tready);
                acc = s_axis_tready;
                @(posedge clk);
                #1;
                tries++;
                if (!acc && tries > 16) begin
                    check("accept_timeout", 0, 1);
                    s_axis_tvalid = 1'b0;
                    s_axis_tlast  = 1'b0;
                    m_axis_tready = 1'b1;
                    return;
                end
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        bit data_ok;
        bit last_ok;
        vecs[0]  = mk(LOCAL_IP, 8'd17, 8'h45, 8'h00, 16'd28, 0, 8, 0, 0, 0, 0, 8, 0, 1);
        vecs[1]  = mk(LOCAL_IP, 8'd17, 8'h45, 8'h00, 16'd28, 0, 8, 18, 0, 0, 0, 8, 0, 1);
`ifdef AXI_IP_RX_CHECKSUM_EN
        vecs[2]  = mk(LOCAL_IP, 8'd17, 8'h45, 8'h00, 16'd28, 1, 8, 0, 0, 0, 1, 0, 0, 0);
`else
        vecs[2]  = mk(LOCAL_IP, 8'd17, 8'h45, 8'h00, 16'd28, 1, 8, 0, 0, 0, 0, 8, 0, 1);
`endif
        vecs[3]  = mk(32'hc0a80603, 8'd17, 8'h45, 8'h00, 16'd28, 0, 8, 0, 0, 0, 1, 0, 0, 0);
        vecs[4]  = mk(LOCAL_IP, 8'd6,  8'h45, 8'h00, 16'd28, 0, 8, 0, 0, 0, 1, 0, 0, 0);
        vecs[5]  = mk(LOCAL_IP, 8'd17, 8'h46, 8'h00, 16'd28, 0, 8, 0, 0, 0, 1, 0, 0, 0);
        vecs[6]  = mk(LOCAL_IP, 8'd17, 8'h45, 8'h20, 16'd28, 0, 8, 0, 0, 0, 1, 0, 0, 0);
        vecs[7]  = mk(32'hffffffff, 8'd17, 8'h45, 8'h00, 16'd28, 0, 8, 0, 0, 0, 0, 8, 0, 1);
        vecs[8]  = mk(LOCAL_IP, 8'd17, 8'h45, 8'h00, 16'd100, 0, 10, 0, 0, 0, 0, 10, 1, 1);
        vecs[9]  = mk(LOCAL_IP, 8'd17, 8'h45, 8'h00, 16'd28, 0, 8, 0, 10, 0, 1, 0, 0, 0);
        vecs[10] = mk(LOCAL_IP, 8'd17, 8'h45, 8'h00, 16'd21, 0, 1, 0, 0, 0, 0, 1, 0, 1);
        vecs[11] = mk(LOCAL_IP, 8'd17, 8'h45, 8'h00, 16'd20, 0, 0, 5, 0, 0, 1, 0, 0, 0);
        vecs[12] = mk(LOCAL_IP, 8'd17, 8'h45, 8'h00, 16'd40, 0, 20, 0, 0, 1, 0, 20, 0, 1);

        aresetn       = 1'b0;
        s_axis_tdata  = 8'h00;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              {m_axis_tvalid, m_axis_tlast, m_axis_tuser, ip_hdr_valid, ip_drop, s_axis_tready},
              6'b000001);
        check("reset_fields", {ip_hdr_src_ip, ip_hdr_length} | {16'd0, ip_hdr_dst_ip}, 64'd0);
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        @(posedge clk);
        #1;

        for (int t = 0; t < 13; t++) begin
            out_q.delete();
            drop_cnt = 0;
            build_frame(vecs[t]);
            send_frame(vecs[t]);
            $display("vec %0d: frame_bytes=%0d out_bytes=%0d drops=%0d hdr_valid=%0d len=%0d",
                     t, frame.size(), out_q.size(), drop_cnt, ip_hdr_valid, ip_hdr_length);
            check($sformatf("v%0d_drop_cnt", t), drop_cnt, vecs[t].exp_drop);
            check($sformatf("v%0d_out_count", t), out_q.size(), vecs[t].exp_n);
            if (out_q.size() > 0) begin
                data_ok = 1'b1;
                last_ok = 1'b1;
                for (int k = 0; k < out_q.size(); k++) begin
                    if (out_q[k].d !== 8'hA0 + 8'(k)) data_ok = 1'b0;
                    if (out_q[k].l !== (k == out_q.size() - 1)) last_ok = 1'b0;
                end
                check($sformatf("v%0d_payload_data", t), data_ok, 1);
                check($sformatf("v%0d_tlast_pos", t), last_ok, 1);
                check($sformatf("v%0d_tuser", t), out_q[out_q.size()-1].u, vecs[t].exp_tuser);
            end
            check($sformatf("v%0d_hdr_valid", t), ip_hdr_valid, vecs[t].exp_valid);
            if (vecs[t].exp_valid) begin
                check($sformatf("v%0d_hdr_length", t), ip_hdr_length, vecs[t].tl - 16'd20);
                check($sformatf("v%0d_hdr_src", t), ip_hdr_src_ip, SRC_IP);
                check($sformatf("v%0d_hdr_dst", t), ip_hdr_dst_ip, vecs[t].dst);
            end
        end

        // Reset asserted while payload is flowing.
        build_frame(vecs[0]);
        for (int i = 0; i < 23; i++) begin
            s_axis_tdata  = frame[i];
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = 1'b0;
            @(posedge clk);
            #1;
        end
        s_axis_tdata = frame[23];
        aresetn      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midreset_outputs",
              {m_axis_tvalid, m_axis_tlast, m_axis_tuser, ip_hdr_valid, ip_drop, s_axis_tready},
              6'b000001);
        check("midreset_length", ip_hdr_length, 16'd0);
        $display("midreset: m_tvalid=%0d hdr_valid=%0d s_tready=%0d",
                 m_axis_tvalid, ip_hdr_valid, s_axis_tready);
        @(posedge clk);
        #1;
        aresetn       = 1'b1;
        s_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
        out_q.delete();
        drop_cnt = 0;
        send_frame(vecs[0]);
        $display("post-reset packet: out_bytes=%0d drops=%0d", out_q.size(), drop_cnt);
        check("postreset_out_count", out_q.size(), 8);
        check("postreset_drop_cnt", drop_cnt, 0);
        check("postreset_hdr_length", ip_hdr_length, 16'd8);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
